ray_tracer_mt: RTL and testbench
================================

RAY_TRACER_MT -- requirements
Module: ray_tracer_mt

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: concurrent ray contexts, ≥1.
REQ-002 SHALL have parameter VEC_W, default 72: fp_vec3/fp_color width (3×24).
REQ-003 SHALL have parameter MAT_W, default 64: opaque material width.
REQ-004 SHALL have parameter ONE_VEC, default {3{FP_ONE}}: initial ray_color.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports in_valid/in_ready  in/out  1/1  new-ray handshake.
REQ-008 SHALL have port in_ray  in  2*VEC_W+21  {origin, dir, pixel_h[10:0], pixel_v[9:0]}.
REQ-009 SHALL have ports out_valid/out_ready  out/in  1/1  finished-pixel handshake.
REQ-010 SHALL have port out_pix  out  VEC_W+29  {color, pixel_h, pixel_v, bounces[7:0]}.
REQ-011 SHALL have ports max_bounces  in  8, and sky_color  in  VEC_W; both quasi-static.
REQ-012 SHALL have ports intx_req_valid/intx_req_ready  out/in  1/1, and intx_req_data  out  2*VEC_W  {origin, dir}.
REQ-013 SHALL have ports intx_resp_valid  in  1, and intx_resp_data  in  1+2*VEC_W+MAT_W  {hit, pos, norm, mat}.
REQ-014 SHALL have ports rflx_req_valid/rflx_req_ready  out/in  1/1, and rflx_req_data  out  5*VEC_W+MAT_W  {dir, color, light, pos, norm, mat}.
REQ-015 SHALL have ports rflx_resp_valid  in  1, and rflx_resp_data  in  4*VEC_W  {new_dir, new_origin, new_color, new_light}.

Function
REQ-016 Each slot SHALL run FSM FREE→WAIT_I→IN_I→(WAIT_R→IN_R→WAIT_I | DONE)→FREE and hold origin, dir, color, light, hit record, pixel coordinates, and an 8-bit bounce count.
REQ-017 in_ready SHALL equal 1 iff ≥1 slot is FREE in the current registered state; on accept, the lowest-index FREE slot SHALL load in_ray with light=0, color=ONE_VEC, bounce=0, and enter WAIT_I.
REQ-018 Intersector SHALL have ≤1 outstanding request; when idle, round-robin (from last-granted+1) SHALL pick a WAIT_I slot, and intx_req_valid/intx_req_data SHALL be registered and held stable until intx_req_ready.
REQ-019 On request handshake the slot SHALL move to IN_I; the next intx_resp_valid SHALL be routed to that slot and free the intersector.
REQ-020 On hit=1 the slot SHALL store pos/norm/mat and enter WAIT_R; on hit=0 it SHALL enter DONE with color = sky_color if bounce==0, else light.
REQ-021 Reflector SHALL have ≤1 outstanding request, with arbitration and handshake identical to REQ-018/019 over WAIT_R slots.
REQ-022 On rflx_resp_valid the slot SHALL latch the four new values; if bounce+1 ≥ max(max_bounces,1) it SHALL enter DONE with color=new_light, else bounce SHALL increment and the slot SHALL enter WAIT_I.
REQ-023 Output SHALL round-robin among DONE slots; out_pix SHALL be held stable while out_valid=1 and out_ready=0; on handshake the slot SHALL become FREE, and it SHALL be reusable the following cycle, not the same cycle.
REQ-024 Latency, single ray on an idle block: intx_req_valid SHALL assert 1 cycle after in handshake, rflx_req_valid 1 cycle after intx response, and out_valid 1 cycle after the final response.
REQ-025 A response arriving with no request outstanding SHALL be ignored; intersector and reflector responses in the same cycle SHALL both be processed.
REQ-026 Bounce count SHALL saturate at 255, with no wrap.
REQ-027 Rays MAY complete out of order; pixel coordinates SHALL always accompany their own ray.

Reset
REQ-028 While rst=0: all slots FREE, arbiter pointers 0, in_ready=0, out_valid=0, intx_req_valid=0, rflx_req_valid=0, out_pix=0, outstanding flags cleared.
REQ-029 Reset asserted mid-operation SHALL discard all rays; responses to pre-reset requests SHALL be ignored per REQ-025.
REQ-030 in_ready SHALL assert the first cycle after rst deasserts.

Verification
REQ-031 Single ray, max_bounces=3, intersector always hits, reflector new_light=L_k → out color=L_3, bounces=3, exactly 3 intx and 3 rflx requests.
REQ-032 Miss on first intersect, sky_color=0x3F0000_3F0000_3F0000 → out color=sky_color, bounces=0; miss after 1 bounce → color=L_1.
REQ-033 NUM_SLOTS=4, push 5 rays back-to-back → in_ready low after 4th accept, 5th accepted the cycle after the first out handshake; all 5 pixel coordinates returned exactly once.
REQ-034 out_ready held 0 for 20 cycles → out_pix stable, no slot lost; intx_req_ready stalled for 10 cycles → intx_req_data unchanged.
REQ-035 max_bounces=0 → behaves as 1 (one reflection, bounces=1).
REQ-036 rst pulsed with 3 rays in flight, then a stale intx_resp_valid → ignored, no out_valid, in_ready=1.

Source files
------------

// File: rtl/ray_tracer_mt.sv
// Multi-context ray scheduler: NUM_SLOTS rays share one intersector and one reflector.
// Each slot walks FREE -> WAIT_I -> IN_I -> (WAIT_R -> IN_R -> WAIT_I | DONE) -> FREE.
module ray_tracer_mt #(
  parameter int               NUM_SLOTS = 4,
  parameter int               VEC_W     = 72,
  parameter int               MAT_W     = 64,
  parameter logic [VEC_W-1:0] ONE_VEC   = {3{24'h3F8000}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*VEC_W+20:0]      in_ray,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VEC_W+28:0]        out_pix,
  input  logic [7:0]               max_bounces,
  input  logic [VEC_W-1:0]         sky_color,
  output logic                     intx_req_valid,
  input  logic                     intx_req_ready,
  output logic [2*VEC_W-1:0]       intx_req_data,
  input  logic                     intx_resp_valid,
  input  logic [2*VEC_W+MAT_W:0]   intx_resp_data,
  output logic                     rflx_req_valid,
  input  logic                     rflx_req_ready,
  output logic [5*VEC_W+MAT_W-1:0] rflx_req_data,
  input  logic                     rflx_resp_valid,
  input  logic [4*VEC_W-1:0]       rflx_resp_data
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [2:0] {S_FREE, S_WAIT_I, S_IN_I, S_WAIT_R, S_IN_R, S_DONE} slot_state_t;

  slot_state_t      state_reg  [NUM_SLOTS];
  slot_state_t      state_next [NUM_SLOTS];
  logic [VEC_W-1:0] origin_reg [NUM_SLOTS], origin_next [NUM_SLOTS];
  logic [VEC_W-1:0] dir_reg    [NUM_SLOTS], dir_next    [NUM_SLOTS];
  logic [VEC_W-1:0] color_reg  [NUM_SLOTS], color_next  [NUM_SLOTS];
  logic [VEC_W-1:0] light_reg  [NUM_SLOTS], light_next  [NUM_SLOTS];
  logic [VEC_W-1:0] pos_reg    [NUM_SLOTS], pos_next    [NUM_SLOTS];
  logic [VEC_W-1:0] norm_reg   [NUM_SLOTS], norm_next   [NUM_SLOTS];
  logic [MAT_W-1:0] mat_reg    [NUM_SLOTS], mat_next    [NUM_SLOTS];
  logic [20:0]      pix_reg    [NUM_SLOTS], pix_next    [NUM_SLOTS];
  logic [7:0]       bounce_reg [NUM_SLOTS], bounce_next [NUM_SLOTS];

  logic                     run_reg;
  logic                     intx_valid_reg, intx_pend_reg, rflx_valid_reg, rflx_pend_reg, out_valid_reg;
  logic [SW-1:0]            intx_slot_reg, intx_ptr_reg, rflx_slot_reg, rflx_ptr_reg, out_slot_reg, out_ptr_reg;
  logic [2*VEC_W-1:0]       intx_data_reg;
  logic [5*VEC_W+MAT_W-1:0] rflx_data_reg;
  logic [VEC_W+28:0]        out_pix_reg;

  logic                 free_found, in_fire, intx_resp_fire, rflx_resp_fire, intx_hs, rflx_hs, out_hs;
  logic                 intx_grant, rflx_grant, out_grant;
  logic [SW-1:0]        free_idx;
  logic [SW:0]          intx_pick, rflx_pick, out_pick;
  logic [NUM_SLOTS-1:0] intx_req_vec, rflx_req_vec, out_req_vec;
  logic [7:0]           mb_eff;
  logic [8:0]           bounce_inc;

  wire              resp_hit  = intx_resp_data[2*VEC_W+MAT_W];
  wire [VEC_W-1:0]  resp_pos  = intx_resp_data[2*VEC_W+MAT_W-1 -: VEC_W];
  wire [VEC_W-1:0]  resp_norm = intx_resp_data[VEC_W+MAT_W-1 -: VEC_W];
  wire [MAT_W-1:0]  resp_mat  = intx_resp_data[MAT_W-1:0];

  // Round-robin search starting one past the last grant; MSB flags a hit.
  function automatic logic [SW:0] rr_pick(input logic [NUM_SLOTS-1:0] req, input logic [SW-1:0] ptr);
    logic [SW:0] res;
    int          idx;
    res = '0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      idx = (int'(ptr) + k) % NUM_SLOTS;
      if (!res[SW] && req[idx]) res = {1'b1, idx[SW-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_next[i]  = state_reg[i];
      origin_next[i] = origin_reg[i];
      dir_next[i]    = dir_reg[i];
      color_next[i]  = color_reg[i];
      light_next[i]  = light_reg[i];
      pos_next[i]    = pos_reg[i];
      norm_next[i]   = norm_reg[i];
      mat_next[i]    = mat_reg[i];
      pix_next[i]    = pix_reg[i];
      bounce_next[i] = bounce_reg[i];
      if (!free_found && state_reg[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = i[SW-1:0];
      end
    end
    in_fire        = run_reg & free_found & in_valid;
    intx_resp_fire = intx_resp_valid & intx_pend_reg;
    rflx_resp_fire = rflx_resp_valid & rflx_pend_reg;
    intx_hs        = intx_valid_reg & intx_req_ready;
    rflx_hs        = rflx_valid_reg & rflx_req_ready;
    out_hs         = out_valid_reg & out_ready;
    mb_eff         = (max_bounces == 8'd0) ? 8'd1 : max_bounces;
    bounce_inc     = '0;

    if (in_fire) begin
      state_next[free_idx]  = S_WAIT_I;
      origin_next[free_idx] = in_ray[2*VEC_W+20 -: VEC_W];
      dir_next[free_idx]    = in_ray[VEC_W+20 -: VEC_W];
      color_next[free_idx]  = ONE_VEC;
      light_next[free_idx]  = '0;
      pix_next[free_idx]    = in_ray[20:0];
      bounce_next[free_idx] = 8'd0;
    end
    if (intx_resp_fire) begin
      if (resp_hit) begin
        state_next[intx_slot_reg] = S_WAIT_R;
        pos_next[intx_slot_reg]   = resp_pos;
        norm_next[intx_slot_reg]  = resp_norm;
        mat_next[intx_slot_reg]   = resp_mat;
      end else begin
        state_next[intx_slot_reg] = S_DONE;
        color_next[intx_slot_reg] = (bounce_reg[intx_slot_reg] == 8'd0) ? sky_color
                                                                         : light_reg[intx_slot_reg];
      end
    end
    if (rflx_resp_fire) begin
      dir_next[rflx_slot_reg]    = rflx_resp_data[4*VEC_W-1 -: VEC_W];
      origin_next[rflx_slot_reg] = rflx_resp_data[3*VEC_W-1 -: VEC_W];
      color_next[rflx_slot_reg]  = rflx_resp_data[2*VEC_W-1 -: VEC_W];
      light_next[rflx_slot_reg]  = rflx_resp_data[VEC_W-1:0];
      bounce_inc                 = {1'b0, bounce_reg[rflx_slot_reg]} + 9'd1;
      bounce_next[rflx_slot_reg] = bounce_inc[8] ? 8'hFF : bounce_inc[7:0];
      // A finished ray reports its final light as the pixel colour.
      if (bounce_inc >= {1'b0, mb_eff}) begin
        state_next[rflx_slot_reg] = S_DONE;
        color_next[rflx_slot_reg] = rflx_resp_data[VEC_W-1:0];
      end else begin
        state_next[rflx_slot_reg] = S_WAIT_I;
      end
    end
    if (intx_hs) state_next[intx_slot_reg] = S_IN_I;
    if (rflx_hs) state_next[rflx_slot_reg] = S_IN_R;
    if (out_hs)  state_next[out_slot_reg]  = S_FREE;

    // Arbitrate on next-state so a slot can be issued on the same edge it becomes eligible.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      intx_req_vec[i] = (state_next[i] == S_WAIT_I);
      rflx_req_vec[i] = (state_next[i] == S_WAIT_R);
      out_req_vec[i]  = (state_next[i] == S_DONE);
    end
    intx_pick  = rr_pick(intx_req_vec, intx_ptr_reg);
    rflx_pick  = rr_pick(rflx_req_vec, rflx_ptr_reg);
    out_pick   = rr_pick(out_req_vec, out_ptr_reg);
    intx_grant = intx_pick[SW] & ~intx_valid_reg & (~intx_pend_reg | intx_resp_fire);
    rflx_grant = rflx_pick[SW] & ~rflx_valid_reg & (~rflx_pend_reg | rflx_resp_fire);
    out_grant  = out_pick[SW] & (~out_valid_reg | out_hs);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) state_reg[i] <= S_FREE;
      run_reg        <= 1'b0;
      intx_valid_reg <= 1'b0;
      intx_pend_reg  <= 1'b0;
      intx_slot_reg  <= '0;
      intx_ptr_reg   <= '0;
      intx_data_reg  <= '0;
      rflx_valid_reg <= 1'b0;
      rflx_pend_reg  <= 1'b0;
      rflx_slot_reg  <= '0;
      rflx_ptr_reg   <= '0;
      rflx_data_reg  <= '0;
      out_valid_reg  <= 1'b0;
      out_slot_reg   <= '0;
      out_ptr_reg    <= '0;
      out_pix_reg    <= '0;
    end else begin
      run_reg <= 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) state_reg[i] <= state_next[i];
      if (intx_hs) begin
        intx_valid_reg <= 1'b0;
        intx_pend_reg  <= 1'b1;
      end
      if (intx_resp_fire) intx_pend_reg <= 1'b0;
      if (intx_grant) begin
        intx_valid_reg <= 1'b1;
        intx_slot_reg  <= intx_pick[SW-1:0];
        intx_ptr_reg   <= intx_pick[SW-1:0];
        intx_data_reg  <= {origin_next[intx_pick[SW-1:0]], dir_next[intx_pick[SW-1:0]]};
      end
      if (rflx_hs) begin
        rflx_valid_reg <= 1'b0;
        rflx_pend_reg  <= 1'b1;
      end
      if (rflx_resp_fire) rflx_pend_reg <= 1'b0;
      if (rflx_grant) begin
        rflx_valid_reg <= 1'b1;
        rflx_slot_reg  <= rflx_pick[SW-1:0];
        rflx_ptr_reg   <= rflx_pick[SW-1:0];
        rflx_data_reg  <= {dir_next[rflx_pick[SW-1:0]], color_next[rflx_pick[SW-1:0]],
                           light_next[rflx_pick[SW-1:0]], pos_next[rflx_pick[SW-1:0]],
                           norm_next[rflx_pick[SW-1:0]], mat_next[rflx_pick[SW-1:0]]};
      end
      if (out_hs) out_valid_reg <= 1'b0;
      if (out_grant) begin
        out_valid_reg <= 1'b1;
        out_slot_reg  <= out_pick[SW-1:0];
        out_ptr_reg   <= out_pick[SW-1:0];
        out_pix_reg   <= {color_next[out_pick[SW-1:0]], pix_next[out_pick[SW-1:0]],
                          bounce_next[out_pick[SW-1:0]]};
      end
    end
  end

  // Ray payload needs no reset: a slot is always fully loaded before it is used.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      origin_reg[i] <= origin_next[i];
      dir_reg[i]    <= dir_next[i];
      color_reg[i]  <= color_next[i];
      light_reg[i]  <= light_next[i];
      pos_reg[i]    <= pos_next[i];
      norm_reg[i]   <= norm_next[i];
      mat_reg[i]    <= mat_next[i];
      pix_reg[i]    <= pix_next[i];
      bounce_reg[i] <= bounce_next[i];
    end
  end

  assign in_ready       = run_reg & free_found;
  assign intx_req_valid = intx_valid_reg;
  assign intx_req_data  = intx_data_reg;
  assign rflx_req_valid = rflx_valid_reg;
  assign rflx_req_data  = rflx_data_reg;
  assign out_valid      = out_valid_reg;
  assign out_pix        = out_pix_reg;
endmodule

// File: tb/tb_ray_tracer_mt.sv
// Directed bench for ray_tracer_mt with behavioural intersector/reflector responders.
module tb_ray_tracer_mt;
  localparam int VW = 72;
  localparam int MW = 64;
  localparam logic [VW-1:0] ONE = {3{24'h3F8000}};

  logic              clk = 1'b0, rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*VW+20:0]  in_ray = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [VW+28:0]    out_pix;
  logic [7:0]        max_bounces = 8'd3;
  logic [VW-1:0]     sky_color = '0;
  logic              intx_req_valid;
  logic              intx_req_ready = 1'b0;
  logic [2*VW-1:0]   intx_req_data;
  logic              intx_resp_valid = 1'b0;
  logic [2*VW+MW:0]  intx_resp_data = '0;
  logic              rflx_req_valid;
  logic              rflx_req_ready = 1'b0;
  logic [5*VW+MW-1:0] rflx_req_data;
  logic              rflx_resp_valid = 1'b0;
  logic [4*VW-1:0]   rflx_resp_data = '0;

  int total = 0, bad = 0, cyc = 0;
  // responder state (written only by the responder process)
  int intx_cnt = 0, rflx_cnt = 0, intx_n = 0, rflx_k = 0;
  int last_intx_resp_cyc = -100, last_rflx_resp_cyc = -100, rflx_lat = -1;
  logic intx_pend = 1'b0, rflx_pend = 1'b0, rflx_prev = 1'b0;
  logic [5*VW+MW-1:0] rflx_first_data = '0;
  // controls written only by the main process
  int intx_base = 0, rflx_base = 0, miss_n = 0, stale_at = -1;
  logic intx_stall = 1'b0;

  ray_tracer_mt dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ray(in_ray),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .max_bounces(max_bounces), .sky_color(sky_color),
    .intx_req_valid(intx_req_valid), .intx_req_ready(intx_req_ready), .intx_req_data(intx_req_data),
    .intx_resp_valid(intx_resp_valid), .intx_resp_data(intx_resp_data),
    .rflx_req_valid(rflx_req_valid), .rflx_req_ready(rflx_req_ready), .rflx_req_data(rflx_req_data),
    .rflx_resp_valid(rflx_resp_valid), .rflx_resp_data(rflx_resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] lvec(input logic [23:0] base, input int k);
    return {3{base + 24'(k)}};
  endfunction
  function automatic logic [MW-1:0] matv(input int n);
    return 64'hA5A5_0000_0000_0000 | 64'(n);
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Intersector/reflector: one-cycle response after each request handshake.
  always @(negedge clk) begin
    intx_resp_valid = 1'b0;
    rflx_resp_valid = 1'b0;
    if (intx_pend) begin
      intx_pend       = 1'b0;
      intx_resp_valid = 1'b1;
      intx_resp_data  = (intx_n == miss_n) ? '0
                        : {1'b1, lvec(24'h0A0000, intx_n), lvec(24'h0B0000, intx_n), matv(intx_n)};
      last_intx_resp_cyc = cyc;
    end else if (cyc == stale_at) begin
      intx_resp_valid = 1'b1;
      intx_resp_data  = {1'b1, lvec(24'h0A0000, 9), lvec(24'h0B0000, 9), matv(9)};
    end
    if (rflx_pend) begin
      rflx_pend       = 1'b0;
      rflx_resp_valid = 1'b1;
      rflx_resp_data  = {lvec(24'h0D0000, rflx_k), lvec(24'h0E0000, rflx_k),
                         lvec(24'h0C0000, rflx_k), lvec(24'h400000, rflx_k)};
      last_rflx_resp_cyc = cyc;
    end
    if (rflx_req_valid && !rflx_prev) rflx_lat = cyc - last_intx_resp_cyc;
    rflx_prev      = rflx_req_valid;
    intx_req_ready = !intx_stall;
    rflx_req_ready = 1'b1;
    if (intx_req_valid && intx_req_ready) begin
      intx_cnt++;
      intx_n    = intx_cnt - intx_base;
      intx_pend = 1'b1;
    end
    if (rflx_req_valid && rflx_req_ready) begin
      rflx_cnt++;
      rflx_k    = rflx_cnt - rflx_base;
      rflx_pend = 1'b1;
      if (rflx_k == 1) rflx_first_data = rflx_req_data;
    end
  end

  task automatic new_test();
    intx_base = intx_cnt;
    rflx_base = rflx_cnt;
    @(negedge clk);
  endtask

  task automatic push(input logic [2*VW+20:0] ray);
    in_ray   = ray;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_out_seen"}, 512'(out_valid), 512'(1));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen [5];
    int got, h;
    logic [VW+28:0]   pix_snap;
    logic [2*VW-1:0]  req_snap;
    logic             saw;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_intx_valid", 512'(intx_req_valid), 512'(0));
    chk("rst_rflx_valid", 512'(rflx_req_valid), 512'(0));
    chk("rst_out_pix", 512'(out_pix), 512'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));

    // three bounces, always hit
    max_bounces = 8'd3;
    miss_n = 0;
    new_test();
    push({lvec(24'h111111, 0), lvec(24'h222222, 0), 11'd100, 10'd50});
    chk("a_intx_lat", 512'(intx_req_valid), 512'(1));
    chk("a_intx_data", 512'(intx_req_data), 512'({lvec(24'h111111, 0), lvec(24'h222222, 0)}));
    wait_out("a");
    chk("a_out_lat", 512'(cyc - last_rflx_resp_cyc), 512'(1));
    chk("a_color", 512'(out_pix[VW+28:29]), 512'(lvec(24'h400000, 3)));
    chk("a_bounces", 512'(out_pix[7:0]), 512'(3));
    chk("a_pix", 512'(out_pix[28:8]), 512'({11'd100, 10'd50}));
    chk("a_rflx_lat", 512'(rflx_lat), 512'(1));
    chk("a_n_intx", 512'(intx_cnt - intx_base), 512'(3));
    chk("a_n_rflx", 512'(rflx_cnt - rflx_base), 512'(3));
    chk("a_rflx_data", 512'(rflx_first_data),
        512'({lvec(24'h222222, 0), ONE, {VW{1'b0}}, lvec(24'h0A0000, 1), lvec(24'h0B0000, 1), matv(1)}));
    pop();
    chk("a_out_clear", 512'(out_valid), 512'(0));

    // miss on first intersect returns sky
    sky_color = {3{24'h3F0000}};
    miss_n = 1;
    new_test();
    push({lvec(24'h333333, 0), lvec(24'h444444, 0), 11'd7, 10'd3});
    wait_out("b1");
    chk("b1_color", 512'(out_pix[VW+28:29]), 512'({3{24'h3F0000}}));
    chk("b1_bounces", 512'(out_pix[7:0]), 512'(0));
    chk("b1_n_rflx", 512'(rflx_cnt - rflx_base), 512'(0));
    pop();

    // miss after one bounce returns L_1, extreme pixel coordinates
    miss_n = 2;
    new_test();
    push({lvec(24'h555555, 0), lvec(24'h666666, 0), 11'd2047, 10'd1023});
    wait_out("b2");
    chk("b2_out_lat", 512'(cyc - last_intx_resp_cyc), 512'(1));
    chk("b2_color", 512'(out_pix[VW+28:29]), 512'(lvec(24'h400000, 1)));
    chk("b2_bounces", 512'(out_pix[7:0]), 512'(1));
    chk("b2_pix", 512'(out_pix[28:8]), 512'({11'd2047, 10'd1023}));
    pop();

    // max_bounces=0 behaves as 1
    max_bounces = 8'd0;
    miss_n = 0;
    new_test();
    push({lvec(24'h777777, 0), lvec(24'h888888, 0), 11'd5, 10'd6});
    wait_out("c");
    chk("c_color", 512'(out_pix[VW+28:29]), 512'(lvec(24'h400000, 1)));
    chk("c_bounces", 512'(out_pix[7:0]), 512'(1));
    chk("c_n_rflx", 512'(rflx_cnt - rflx_base), 512'(1));
    pop();

    // five rays into four slots, output stalled
    max_bounces = 8'd1;
    new_test();
    for (int i = 0; i < 4; i++) begin
      chk("d_in_ready", 512'(in_ready), 512'(1));
      in_ray   = {lvec(24'h010000, i), lvec(24'h020000, i), 11'(10 + i), 10'(20 + i)};
      in_valid = 1'b1;
      @(negedge clk);
    end
    chk("d_full", 512'(in_ready), 512'(0));
    in_ray = {lvec(24'h010000, 4), lvec(24'h020000, 4), 11'd14, 10'd24};
    wait_out("d");
    pix_snap = out_pix;
    repeat (20) @(negedge clk);
    chk("d_hold_pix", 512'(out_pix), 512'(pix_snap));
    chk("d_hold_valid", 512'(out_valid), 512'(1));
    chk("d_hold_full", 512'(in_ready), 512'(0));
    for (int i = 0; i < 5; i++) seen[i] = 0;
    got = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 300 && got < 5; n++) begin
      if (n == 1) chk("d_reuse", 512'(in_ready), 512'(1));
      if (n == 2) in_valid = 1'b0;
      if (out_valid) begin
        h = int'(out_pix[28:18]);
        if (h >= 10 && h <= 14) seen[h - 10]++;
        chk("d_pair", 512'(out_pix[17:8]), 512'(h + 10));
        got++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("d_got", 512'(got), 512'(5));
    for (int i = 0; i < 5; i++) chk("d_once", 512'(seen[i]), 512'(1));

    // intersector request held while stalled
    intx_stall = 1'b1;
    repeat (2) @(negedge clk);
    new_test();
    push({lvec(24'h0F0F0F, 0), lvec(24'h0E0E0E, 0), 11'd1, 10'd2});
    chk("e_req_valid", 512'(intx_req_valid), 512'(1));
    req_snap = intx_req_data;
    repeat (10) @(negedge clk);
    chk("e_hold_valid", 512'(intx_req_valid), 512'(1));
    chk("e_hold_data", 512'(intx_req_data), 512'(req_snap));
    chk("e_data", 512'(intx_req_data), 512'({lvec(24'h0F0F0F, 0), lvec(24'h0E0E0E, 0)}));
    intx_stall = 1'b0;
    wait_out("e");
    chk("e_color", 512'(out_pix[VW+28:29]), 512'(lvec(24'h400000, 1)));
    chk("e_pix", 512'(out_pix[28:8]), 512'({11'd1, 10'd2}));
    pop();

    // reset with three rays in flight, then a stale response
    new_test();
    for (int i = 0; i < 3; i++) begin
      in_ray   = {lvec(24'h090000, i), lvec(24'h080000, i), 11'(30 + i), 10'(40 + i)};
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("f_rst_in_ready", 512'(in_ready), 512'(0));
    chk("f_rst_out_valid", 512'(out_valid), 512'(0));
    rst = 1'b1;
    stale_at = cyc + 2;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || rflx_req_valid || intx_req_valid) saw = 1'b1;
    end
    chk("f_quiet", 512'(saw), 512'(0));
    chk("f_in_ready", 512'(in_ready), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
